// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - fetch-stage PC register with next-PC select, exception/eret entry and return-address stack
module pc_gen #(
  parameter logic [31:0] RESET_PC  = 32'h0000_3000,
  parameter logic [31:0] EXC_VEC   = 32'h0000_4180,
  parameter int          RAS_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           stall,
  input  logic [31:0]                    pc4_D,
  input  logic [25:0]                    i26,
  input  logic [2:0]                     npc_sel,
  input  logic                           cmp_out,
  input  logic [31:0]                    jr_reg,
  input  logic                           exc_req,
  input  logic                           eret,
  input  logic [31:0]                    epc,
  output logic [31:0]                    pc_F,
  output logic [$clog2(RAS_DEPTH+1)-1:0] ras_count,
  output logic                           ras_miss,
  output logic                           pc_misalign
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = $clog2(RAS_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(RAS_DEPTH);

  logic [31:0]   ras_mem [RAS_DEPTH];
  logic [PW-1:0] top;
  logic [PW-1:0] top_m1;
  logic [31:0]   ras_top_val;
  logic [31:0]   next_pc;
  logic [31:0]   pc_plus4;
  logic [31:0]   br_off;
  logic [3:0]    pc_d_hi;
  logic          advance;
  logic          is_jal;
  logic          is_ret;

  // Upper nibble of pc4_D - 4: a borrow reaches bit 28 only when bits [27:2] are all zero.
  assign pc_d_hi     = pc4_D[31:28] - {3'b000, (pc4_D[27:2] == 26'd0)};
  assign pc_plus4    = pc_F + 32'd4;
  assign br_off      = {{14{i26[15]}}, i26[15:0], 2'b00};
  assign top_m1      = top - 1'b1;
  assign ras_top_val = ras_mem[top_m1];
  assign advance     = !exc_req && !eret && !stall;
  assign is_jal      = (npc_sel == 3'd3);
  assign is_ret      = (npc_sel == 3'd5);
  assign pc_misalign = (pc_F[1:0] != 2'b00);

  always_comb begin
    next_pc = pc_plus4;
    case (npc_sel)
      3'd1:       next_pc = cmp_out ? (pc4_D + br_off) : pc_plus4;
      3'd2, 3'd3: next_pc = {pc_d_hi, i26, 2'b00};
      3'd4, 3'd5: next_pc = jr_reg;
      default:    next_pc = pc_plus4;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_F      <= RESET_PC;
      top       <= '0;
      ras_count <= '0;
      ras_miss  <= 1'b0;
    end else begin
      ras_miss <= 1'b0;
      if (exc_req) begin
        pc_F <= EXC_VEC;
      end else if (eret) begin
        pc_F <= epc;
      end else if (!stall) begin
        pc_F <= next_pc;
        if (is_jal) begin
          // Circular push: a full stack silently overwrites its oldest entry.
          top <= top + 1'b1;
          if (ras_count != DEPTH_C) ras_count <= ras_count + 1'b1;
        end else if (is_ret) begin
          if (ras_count != '0) begin
            top       <= top_m1;
            ras_count <= ras_count - 1'b1;
            ras_miss  <= (ras_top_val != jr_reg);
          end else begin
            ras_miss  <= 1'b1;
          end
        end
      end
    end
  end

  // Entry contents need no reset; only the pointer and count define validity.
  always_ff @(posedge clk) begin
    if (advance && is_jal) ras_mem[top] <= pc4_D + 32'd4;
  end

endmodule

// File: tb/tb_pc_gen.sv
// tb/tb_pc_gen.sv - directed self-checking bench for pc_gen
module tb_pc_gen;

  logic        clk;
  logic        reset;
  logic        stall;
  logic [31:0] pc4_D;
  logic [25:0] i26;
  logic [2:0]  npc_sel;
  logic        cmp_out;
  logic [31:0] jr_reg;
  logic        exc_req;
  logic        eret;
  logic [31:0] epc;
  logic [31:0] pc_F;
  logic [2:0]  ras_count;
  logic        ras_miss;
  logic        pc_misalign;

  int n_cmp = 0;
  int n_bad = 0;

  pc_gen #(
    .RESET_PC (32'h0000_3000),
    .EXC_VEC  (32'h0000_4180),
    .RAS_DEPTH(4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .pc4_D      (pc4_D),
    .i26        (i26),
    .npc_sel    (npc_sel),
    .cmp_out    (cmp_out),
    .jr_reg     (jr_reg),
    .exc_req    (exc_req),
    .eret       (eret),
    .epc        (epc),
    .pc_F       (pc_F),
    .ras_count  (ras_count),
    .ras_miss   (ras_miss),
    .pc_misalign(pc_misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [2:0] sel, input logic [31:0] p4, input logic [25:0] idx,
                        input logic cmp, input logic [31:0] jr);
    npc_sel = sel;
    pc4_D   = p4;
    i26     = idx;
    cmp_out = cmp;
    jr_reg  = jr;
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; exc_req = 1'b0; eret = 1'b0; epc = '0;
    set_in(3'd0, 32'h0, 26'h0, 1'b0, 32'h0);
    step(); step();
    check("reset_pc", pc_F, 32'h3000);
    check("reset_count", {29'd0, ras_count}, 32'd0);
    check("reset_miss", {31'd0, ras_miss}, 32'd0);
    check("reset_misalign", {31'd0, pc_misalign}, 32'd0);
    reset = 1'b0;

    step(); check("seq1", pc_F, 32'h3004);
    step(); check("seq2", pc_F, 32'h3008);
    step(); check("seq3", pc_F, 32'h300C);

    // jal to 0x3040, then async reset mid-cycle
    set_in(3'd3, 32'h3004, 26'h0000C10, 1'b0, 32'h0);
    step(); check("jal_pc", pc_F, 32'h3040);
    check("jal_count", {29'd0, ras_count}, 32'd1);
    set_in(3'd0, 32'h0, 26'h0, 1'b0, 32'h0);
    #2 reset = 1'b1;
    #1 check("async_reset_pc", pc_F, 32'h3000);
    check("async_reset_count", {29'd0, ras_count}, 32'd0);
    #1 reset = 1'b0;
    step(); check("post_reset_seq", pc_F, 32'h3004);

    // branches
    set_in(3'd1, 32'h3010, 26'h000FFFC, 1'b1, 32'h0);
    step(); check("branch_back", pc_F, 32'h3000);
    cmp_out = 1'b0;
    step(); check("branch_not_taken", pc_F, 32'h3004);
    set_in(3'd1, 32'h3010, 26'h3FF0010, 1'b1, 32'h0);
    step(); check("branch_fwd", pc_F, 32'h3050);

    // wrap and jumps
    set_in(3'd4, 32'h0, 26'h0, 1'b0, 32'hFFFF_FFFC);
    step(); check("jr_top", pc_F, 32'hFFFF_FFFC);
    set_in(3'd0, 32'h0, 26'h0, 1'b0, 32'h0);
    step(); check("wrap", pc_F, 32'h0000_0000);
    set_in(3'd2, 32'h3008, 26'h0000C40, 1'b0, 32'h0);
    step(); check("j_basic", pc_F, 32'h3100);
    set_in(3'd2, 32'h1000_0000, 26'h0000040, 1'b0, 32'h0);
    step(); check("j_borrow", pc_F, 32'h0000_0100);
    set_in(3'd2, 32'h2000_0004, 26'h0000040, 1'b0, 32'h0);
    step(); check("j_region", pc_F, 32'h2000_0100);
    set_in(3'd6, 32'h0, 26'h0, 1'b0, 32'h0);
    step(); check("sel6_seq", pc_F, 32'h2000_0104);

    // RAS hit then miss
    set_in(3'd3, 32'h3004, 26'h0000C00, 1'b0, 32'h0);
    step(); check("ras_push", {29'd0, ras_count}, 32'd1);
    set_in(3'd5, 32'h0, 26'h0, 1'b0, 32'h3008);
    step(); check("ret_hit_pc", pc_F, 32'h3008);
    check("ret_hit_count", {29'd0, ras_count}, 32'd0);
    check("ret_hit_miss", {31'd0, ras_miss}, 32'd0);
    set_in(3'd3, 32'h3004, 26'h0000C00, 1'b0, 32'h0);
    step();
    set_in(3'd5, 32'h0, 26'h0, 1'b0, 32'h4000);
    step(); check("ret_bad_pc", pc_F, 32'h4000);
    check("ret_bad_miss", {31'd0, ras_miss}, 32'd1);
    check("ret_bad_count", {29'd0, ras_count}, 32'd0);
    set_in(3'd0, 32'h0, 26'h0, 1'b0, 32'h0);
    step(); check("miss_pulse_end", {31'd0, ras_miss}, 32'd0);
    check("after_miss_pc", pc_F, 32'h4004);

    // overflow: five pushes, A_k = 0x3k00 + 8
    for (int k = 1; k <= 5; k++) begin
      set_in(3'd3, 32'h3000 + 32'(k) * 32'h100 + 32'h4, 26'h0000C00, 1'b0, 32'h0);
      step();
      check($sformatf("ovf_count%0d", k), {29'd0, ras_count}, (k < 4) ? 32'(k) : 32'd4);
    end
    for (int k = 5; k >= 2; k--) begin
      set_in(3'd5, 32'h0, 26'h0, 1'b0, 32'h3000 + 32'(k) * 32'h100 + 32'h8);
      step();
      check($sformatf("pop_miss%0d", k), {31'd0, ras_miss}, 32'd0);
      check($sformatf("pop_count%0d", k), {29'd0, ras_count}, 32'(k - 2));
    end
    set_in(3'd5, 32'h0, 26'h0, 1'b0, 32'h5000);
    step(); check("underflow_miss", {31'd0, ras_miss}, 32'd1);
    check("underflow_pc", pc_F, 32'h5000);
    check("underflow_count", {29'd0, ras_count}, 32'd0);

    // priorities
    set_in(3'd3, 32'h3604, 26'h0000C00, 1'b0, 32'h0);
    step(); check("prio_push", {29'd0, ras_count}, 32'd1);
    stall = 1'b1;
    set_in(3'd2, 32'h3008, 26'h0000100, 1'b0, 32'h0);
    step(); check("stall_hold", pc_F, 32'h3000);
    npc_sel = 3'd3;
    step(); check("stall_ras", {29'd0, ras_count}, 32'd1);
    exc_req = 1'b1;
    step(); check("stall_exc", pc_F, 32'h4180);
    stall = 1'b0; eret = 1'b1; epc = 32'h3022;
    step(); check("exc_over_eret", pc_F, 32'h4180);
    check("exc_ras", {29'd0, ras_count}, 32'd1);
    exc_req = 1'b0;
    set_in(3'd5, 32'h0, 26'h0, 1'b0, 32'h9999);
    step(); check("eret_pc", pc_F, 32'h3022);
    check("eret_misalign", {31'd0, pc_misalign}, 32'd1);
    check("eret_ras", {29'd0, ras_count}, 32'd1);
    check("eret_no_miss", {31'd0, ras_miss}, 32'd0);
    eret = 1'b0;
    set_in(3'd5, 32'h0, 26'h0, 1'b0, 32'h3608);
    step(); check("final_ret_pc", pc_F, 32'h3608);
    check("final_ret_miss", {31'd0, ras_miss}, 32'd0);
    check("final_ret_count", {29'd0, ras_count}, 32'd0);
    check("final_aligned", {31'd0, pc_misalign}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
